// File: rtl/pkt_router_mc_pkg.sv
// -----------------------------------------------------------------------------
// pkt_router_mc_pkg
// Shared constants for the multicast packet router.
//   KEY_BITS  : width of the routing key carried inside every packet
//   ev_idx_e  : bit positions of the one-cycle event pulses on rt_cnt_out
// -----------------------------------------------------------------------------
package pkt_router_mc_pkg;

    localparam int KEY_BITS = 32;
    localparam int EV_BITS  = 3;

    typedef enum logic [1:0] {
        EV_MISS      = 2'd0,
        EV_TIMEOUT   = 2'd1,
        EV_DELIVERED = 2'd2
    } ev_idx_e;

endpackage

// File: rtl/pkt_router_lookup.sv
// -----------------------------------------------------------------------------
// pkt_router_lookup
// Combinational ternary match of one key against the routing table followed
// by a lowest-index-wins priority select of the matching entry's bitmap.
// Ports:
//   key_in       : packet key
//   reg_key_in   : entry keys, entry i at [i*KEY_BITS +: KEY_BITS]
//   reg_mask_in  : entry masks, same packing as reg_key_in
//   reg_route_in : entry route bitmaps, entry i at [i*NUM_CHANS +: NUM_CHANS]
//   hit_any      : at least one entry matched
//   route        : bitmap of the lowest-index matching entry (0 if none)
// -----------------------------------------------------------------------------
module pkt_router_lookup
    import pkt_router_mc_pkg::*;
#(
    parameter int NUM_CHANS  = 8,
    parameter int NUM_RTREGS = 16
) (
    input  logic [KEY_BITS-1:0]             key_in,
    input  logic [KEY_BITS*NUM_RTREGS-1:0]  reg_key_in,
    input  logic [KEY_BITS*NUM_RTREGS-1:0]  reg_mask_in,
    input  logic [NUM_CHANS*NUM_RTREGS-1:0] reg_route_in,
    output logic                            hit_any,
    output logic [NUM_CHANS-1:0]            route
);

    logic [NUM_RTREGS-1:0] hit;

    // The entry key is compared unmasked, so an entry whose key has bits set
    // outside its mask can never match.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_RTREGS; i++) begin
            hit[i] = ((key_in & reg_mask_in[i*KEY_BITS +: KEY_BITS])
                      == reg_key_in[i*KEY_BITS +: KEY_BITS]);
        end
    end

    // Priority encoder: the first hit found while walking upward is kept.
    always_comb begin
        hit_any = 1'b0;
        route   = '0;
        for (int i = 0; i < NUM_RTREGS; i++) begin
            if (hit[i] && !hit_any) begin
                hit_any = 1'b1;
                route   = reg_route_in[i*NUM_CHANS +: NUM_CHANS];
            end
        end
    end

endmodule

// File: rtl/pkt_router_mc.sv
// -----------------------------------------------------------------------------
// pkt_router_mc
// Multicast packet router: a registered lookup stage (stage 1) holding the
// accepted packet and its outstanding channel bitmap, followed by one output
// register per channel. A packet leaves stage 1 once every targeted channel
// has taken a copy, or when the blocked-cycle budget runs out.
//
// Optional feature: define PKT_ROUTER_MC_DEFAULT_ROUTE_EN to add
// default_route_in, the bitmap used when the table misses.
//
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous reset, active low
//   drop_wait_in     : blocked cycles allowed before drop, all ones = never
//   reg_key_in       : table keys       (32 bits per entry)
//   reg_mask_in      : table masks      (32 bits per entry)
//   reg_route_in     : table bitmaps    (NUM_CHANS bits per entry)
//   default_route_in : miss bitmap (only with PKT_ROUTER_MC_DEFAULT_ROUTE_EN)
//   pkt_in_*         : input packet valid/ready handshake
//   pkt_out_*        : per-channel packet valid/ready handshakes
//   rt_cnt_out       : event pulses [0] miss, [1] timeout drop, [2] delivered
// -----------------------------------------------------------------------------
module pkt_router_mc
    import pkt_router_mc_pkg::*;
#(
    parameter int PKT_BITS   = 72,
    parameter int KEY_LSB    = 8,
    parameter int NUM_CHANS  = 8,
    parameter int NUM_RTREGS = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     drop_wait_in,
    input  logic [KEY_BITS*NUM_RTREGS-1:0]  reg_key_in,
    input  logic [KEY_BITS*NUM_RTREGS-1:0]  reg_mask_in,
    input  logic [NUM_CHANS*NUM_RTREGS-1:0] reg_route_in,
`ifdef PKT_ROUTER_MC_DEFAULT_ROUTE_EN
    input  logic [NUM_CHANS-1:0]            default_route_in,
`endif
    input  logic [PKT_BITS-1:0]             pkt_in_data_in,
    input  logic                            pkt_in_vld_in,
    output logic                            pkt_in_rdy_out,
    output logic [PKT_BITS*NUM_CHANS-1:0]   pkt_out_data_out,
    output logic [NUM_CHANS-1:0]            pkt_out_vld_out,
    input  logic [NUM_CHANS-1:0]            pkt_out_rdy_in,
    output logic [EV_BITS-1:0]              rt_cnt_out
);

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    // Stage 1 state
    logic                  s1_vld_q,  s1_vld_d;
    logic                  s1_miss_q, s1_miss_d;
    logic [PKT_BITS-1:0]   s1_data_q, s1_data_d;
    logic [NUM_CHANS-1:0]  pending_q, pending_d;
    logic [31:0]           wait_cnt_q, wait_cnt_d;

    // Output registers
    logic [NUM_CHANS-1:0]                out_vld_q, out_vld_d;
    logic [NUM_CHANS-1:0][PKT_BITS-1:0]  out_data_q, out_data_d;

    logic [EV_BITS-1:0]    rt_cnt_q, rt_cnt_d;

    // Combinational helpers
    logic [KEY_BITS-1:0]   key;
    logic                  lu_hit;
    logic [NUM_CHANS-1:0]  lu_route;
    logic [NUM_CHANS-1:0]  eff_route;
    logic                  eff_miss;
    logic [NUM_CHANS-1:0]  load;
    logic [NUM_CHANS-1:0]  left;
    logic                  all_loaded;
    logic                  never_drop;
    logic                  timeout;
    logic                  s1_done;
    logic                  accept;

    // ---- lookup on the incoming packet ----
    assign key = pkt_in_data_in[KEY_LSB +: KEY_BITS];

    pkt_router_lookup #(
        .NUM_CHANS  (NUM_CHANS),
        .NUM_RTREGS (NUM_RTREGS)
    ) u_lookup (
        .key_in       (key),
        .reg_key_in   (reg_key_in),
        .reg_mask_in  (reg_mask_in),
        .reg_route_in (reg_route_in),
        .hit_any      (lu_hit),
        .route        (lu_route)
    );

    // A hit with an empty bitmap is treated the same as no hit at all.
    always_comb begin
`ifdef PKT_ROUTER_MC_DEFAULT_ROUTE_EN
        eff_route = (lu_hit && (lu_route != '0)) ? lu_route : default_route_in;
`else
        eff_route = lu_hit ? lu_route : '0;
`endif
        eff_miss = (eff_route == '0);
    end

    // ---- stage 1 retire / handshake decisions ----
    always_comb begin
        load       = s1_vld_q ? (pending_q & (~out_vld_q | pkt_out_rdy_in)) : '0;
        left       = pending_q & ~load;
        all_loaded = (left == '0);
        never_drop = &drop_wait_in;
        // Any load this cycle restarts the budget, so a load beats the timeout.
        timeout    = s1_vld_q && (pending_q != '0) && (load == '0)
                     && (wait_cnt_q == 32'd0) && !never_drop;
        s1_done    = s1_vld_q && (all_loaded || timeout);
        pkt_in_rdy_out = !s1_vld_q || s1_done;
        accept     = pkt_in_vld_in && pkt_in_rdy_out;
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_miss_d = s1_miss_q;
        s1_data_d = s1_data_q;
        pending_d = timeout ? '0 : left;

        if (accept) begin
            s1_vld_d  = 1'b1;
            s1_miss_d = eff_miss;
            s1_data_d = pkt_in_data_in;
            pending_d = eff_route;
        end else if (s1_done) begin
            s1_vld_d  = 1'b0;
            s1_miss_d = 1'b0;
        end

        // A fresh packet also gets a full budget, even when the previous one
        // retired without loading anything (miss or timeout).
        if (!s1_vld_q || (load != '0) || accept) begin
            wait_cnt_d = drop_wait_in;
        end else begin
            wait_cnt_d = sat_dec(wait_cnt_q);
        end
    end

    // ---- output registers ----
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        for (int c = 0; c < NUM_CHANS; c++) begin
            if (load[c]) begin
                out_vld_d[c]  = 1'b1;
                out_data_d[c] = s1_data_q;
            end else if (pkt_out_rdy_in[c]) begin
                out_vld_d[c]  = 1'b0;
            end
        end
    end

    always_comb begin
        rt_cnt_d               = '0;
        rt_cnt_d[EV_MISS]      = s1_vld_q && s1_miss_q;
        rt_cnt_d[EV_TIMEOUT]   = timeout;
        rt_cnt_d[EV_DELIVERED] = s1_vld_q && !s1_miss_q && all_loaded;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q   <= 1'b0;
            s1_miss_q  <= 1'b0;
            s1_data_q  <= '0;
            pending_q  <= '0;
            wait_cnt_q <= 32'd0;
            out_vld_q  <= '0;
            out_data_q <= '0;
            rt_cnt_q   <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_miss_q  <= s1_miss_d;
            s1_data_q  <= s1_data_d;
            pending_q  <= pending_d;
            wait_cnt_q <= wait_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            rt_cnt_q   <= rt_cnt_d;
        end
    end

    assign pkt_out_vld_out  = out_vld_q;
    assign pkt_out_data_out = out_data_q;
    assign rt_cnt_out       = rt_cnt_q;

endmodule

// File: tb/tb_pkt_router_mc.sv
// -----------------------------------------------------------------------------
// tb_pkt_router_mc
// Self-checking bench for pkt_router_mc: directed scenarios plus a randomized
// phase scored against a per-channel expected-packet queue model.
// -----------------------------------------------------------------------------
module tb_pkt_router_mc;

    localparam int PB = 72;
    localparam int NC = 8;
    localparam int NR = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      drop_wait;
    logic [32*NR-1:0] reg_key, reg_mask;
    logic [NC*NR-1:0] reg_route;
    logic [PB-1:0]    in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [PB*NC-1:0] out_data;
    logic [NC-1:0]    out_vld;
    logic [NC-1:0]    out_rdy;
    logic [2:0]       rt_cnt;

    logic [31:0] tbl_key   [NR];
    logic [31:0] tbl_mask  [NR];
    logic [7:0]  tbl_route [NR];

    always_comb begin
        reg_key = '0; reg_mask = '0; reg_route = '0;
        for (int i = 0; i < NR; i++) begin
            reg_key[i*32 +: 32]  = tbl_key[i];
            reg_mask[i*32 +: 32] = tbl_mask[i];
            reg_route[i*NC +: NC] = tbl_route[i];
        end
    end

    pkt_router_mc dut (
        .clk              (clk),
        .reset            (reset),
        .drop_wait_in     (drop_wait),
        .reg_key_in       (reg_key),
        .reg_mask_in      (reg_mask),
        .reg_route_in     (reg_route),
`ifdef PKT_ROUTER_MC_DEFAULT_ROUTE_EN
        .default_route_in (8'h00),
`endif
        .pkt_in_data_in   (in_data),
        .pkt_in_vld_in    (in_vld),
        .pkt_in_rdy_out   (in_rdy),
        .pkt_out_data_out (out_data),
        .pkt_out_vld_out  (out_vld),
        .pkt_out_rdy_in   (out_rdy),
        .rt_cnt_out       (rt_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PB-1:0] exp_q [NC][$];
    int ev_miss = 0, ev_to = 0, ev_del = 0;
    int exp_miss = 0, exp_del = 0;
    int out_cnt = 0, last_out_cyc = 0;

    function automatic logic [7:0] ref_route(input logic [31:0] k);
        for (int i = 0; i < NR; i++)
            if ((k & tbl_mask[i]) == tbl_key[i]) return tbl_route[i];
        return 8'h00;
    endfunction

    function automatic logic [PB-1:0] mk_pkt(input logic [31:0] k);
        logic [31:0] hi;
        logic [7:0]  lo;
        hi = $urandom;
        lo = 8'($urandom);
        return {hi, k, lo};
    endfunction

    task automatic monitor();
        logic [7:0]    r;
        logic [PB-1:0] d;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (in_vld && in_rdy) begin
                    r = ref_route(in_data[39:8]);
                    if (r == 8'h00) exp_miss++;
                    else begin
                        exp_del++;
                        for (int c = 0; c < NC; c++)
                            if (r[c]) exp_q[c].push_back(in_data);
                    end
                end
                for (int c = 0; c < NC; c++) begin
                    if (out_vld[c] && out_rdy[c]) begin
                        out_cnt++;
                        last_out_cyc = cyc;
                        if (exp_q[c].size() == 0) chk($sformatf("unexp_out_ch%0d", c), 1, 0);
                        else begin
                            d = exp_q[c].pop_front();
                            chk($sformatf("data_ch%0d", c), out_data[c*PB +: PB], d);
                        end
                    end
                end
                ev_miss += int'(rt_cnt[0]);
                ev_to   += int'(rt_cnt[1]);
                ev_del  += int'(rt_cnt[2]);
            end
        end
    endtask

    function automatic int q_total();
        int s = 0;
        for (int c = 0; c < NC; c++) s += exp_q[c].size();
        return s;
    endfunction

    task automatic flush();
        for (int c = 0; c < NC; c++) exp_q[c].delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NR; i++) begin
            tbl_key[i] = 32'hFFFF_FFFF; tbl_mask[i] = 32'h0; tbl_route[i] = 8'h00;
        end
    endtask

    // Called just after a rising edge; returns after the handshake edge.
    task automatic send(input logic [PB-1:0] d, output int n);
        logic ok;
        n = 0;
        in_data = d; in_vld = 1'b1;
        do begin
            @(negedge clk); ok = in_rdy;
            @(posedge clk); #1; n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 0, 1);
        in_vld = 1'b0;
    endtask

    // Single packet into an idle router with all channels ready.
    task automatic probe(input string tag, input logic [31:0] k, input logic [7:0] exp_v);
        logic [PB-1:0] d;
        int m0, d0;
        d = mk_pkt(k); m0 = ev_miss; d0 = ev_del;
        in_data = d; in_vld = 1'b1;
        @(negedge clk); chk({tag, "_rdy"}, in_rdy, 1);
        @(posedge clk); #1; in_vld = 1'b0;
        @(negedge clk); chk({tag, "_s1"}, out_vld, 0);
        @(negedge clk); chk({tag, "_vld"}, out_vld, exp_v);
        for (int c = 0; c < NC; c++)
            if (exp_v[c]) chk($sformatf("%s_data%0d", tag, c), out_data[c*PB +: PB], d);
        tick(3);
        chk({tag, "_del"}, ev_del - d0, (exp_v != 0) ? 1 : 0);
        chk({tag, "_miss"}, ev_miss - m0, (exp_v == 0) ? 1 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int n, start, stall, low, bad, oc0, d0, t0, m0, s0;
        logic [PB-1:0] a, b;
        logic [31:0] k;

        reset = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = '1;
        drop_wait = 32'hFFFF_FFFF;
        clear_table();
        fork monitor(); join_none

        #3;
        chk("rst_vld", out_vld, 0);
        chk("rst_rdy", in_rdy, 1);
        chk("rst_cnt", rt_cnt, 0);
        tick(2);
        reset = 1'b1;
        tick(1);

        // ---- T1: single route, latency, throughput ----
        tbl_key[0] = 32'h0000_0100; tbl_mask[0] = 32'hFFFF_FF00; tbl_route[0] = 8'h04;
        tick(1);
        probe("t1", 32'h0000_0123, 8'h04);
        oc0 = out_cnt; stall = 0; start = 0;
        for (int i = 0; i < 100; i++) begin
            in_data = mk_pkt(32'h100 + 32'(i)); in_vld = 1'b1;
            @(negedge clk);
            if (i == 0) start = cyc;
            if (!in_rdy) stall++;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        tick(5);
        chk("t1_stall", stall, 0);
        chk("t1_cnt", out_cnt - oc0, 100);
        chk("t1_span", last_out_cyc - start, 101);

        // ---- T2: priority between overlapping entries ----
        clear_table();
        tbl_key[3] = 32'h0000_AB00; tbl_mask[3] = 32'hFFFF_FF00; tbl_route[3] = 8'h01;
        tbl_key[5] = 32'h0000_0000; tbl_mask[5] = 32'h0000_0000; tbl_route[5] = 8'h80;
        tick(1);
        probe("t2_prio", 32'h0000_AB12, 8'h01);
        probe("t2_low", 32'h0000_5555, 8'h80);

        // ---- T3: multicast with one channel back-pressured ----
        clear_table();
        tbl_key[0] = 32'h0000_0300; tbl_mask[0] = 32'hFFFF_FF00; tbl_route[0] = 8'h91;
        drop_wait = 32'd1000; out_rdy = 8'hEF; d0 = ev_del; t0 = ev_to;
        tick(1);
        a = mk_pkt(32'h0000_0301); b = mk_pkt(32'h0000_0302);
        send(a, n); send(b, n);
        chk("t3_b_accept", n, 1);
        low = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!in_rdy) low++;
            if (!out_vld[4] || out_data[4*PB +: PB] !== a) bad++;
            @(posedge clk); #1;
        end
        chk("t3_stall", low, 10);
        chk("t3_hold", bad, 0);
        chk("t3_del_a", ev_del - d0, 1);
        out_rdy = 8'hFF;
        @(negedge clk); chk("t3_rdy_back", in_rdy, 1);
        tick(4);
        chk("t3_del_ab", ev_del - d0, 2);
        chk("t3_to", ev_to - t0, 0);
        chk("t3_q", q_total(), 0);

        // ---- T4: timeout drop ----
        clear_table();
        tbl_key[0] = 32'h0000_0400; tbl_mask[0] = 32'hFFFF_FF00; tbl_route[0] = 8'h02;
        drop_wait = 32'd5; out_rdy = 8'hFD; t0 = ev_to; d0 = ev_del;
        tick(1);
        a = mk_pkt(32'h0000_0401); b = mk_pkt(32'h0000_0402);
        send(a, n); send(b, n);
        low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!in_rdy) low++;
            @(posedge clk); #1;
        end
        chk("t4_blocked", low, 5);
        chk("t4_to", ev_to - t0, 1);
        chk("t4_del", ev_del - d0, 1);
        @(negedge clk);
        chk("t4_held_vld", out_vld, 8'h02);
        chk("t4_held_data", out_data[1*PB +: PB], a);
        oc0 = out_cnt;
        @(posedge clk); #1; out_rdy = 8'hFF;
        tick(4);
        chk("t4_out_cnt", out_cnt - oc0, 1);
        flush();
        drop_wait = 32'hFFFF_FFFF;

        // ---- T5: table miss and back-to-back accept ----
        tick(1);
        probe("t5_miss", 32'hDEAD_BEEF, 8'h00);
        m0 = ev_miss;
        send(mk_pkt(32'hDEAD_BEEF), n);
        send(mk_pkt(32'h0000_0405), n);
        chk("t5_next_accept", n, 1);
        tick(4);
        chk("t5_miss_cnt", ev_miss - m0, 1);
        chk("t5_q", q_total(), 0);

        // ---- T6: reset with stage 1 and two outputs occupied ----
        clear_table();
        tbl_key[0] = 32'h0000_0600; tbl_mask[0] = 32'hFFFF_FF00; tbl_route[0] = 8'h06;
        out_rdy = 8'hF9;
        tick(1);
        send(mk_pkt(32'h0000_0601), n);
        send(mk_pkt(32'h0000_0602), n);
        tick(2);
        chk("t6_pre_vld", out_vld, 8'h06);
        chk("t6_pre_rdy", in_rdy, 0);
        s0 = ev_miss + ev_to + ev_del;
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_vld", out_vld, 0);
        chk("t6_rst_rdy", in_rdy, 1);
        chk("t6_rst_cnt", rt_cnt, 0);
        flush();
        out_rdy = 8'hFF;
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("t6_no_pulse", ev_miss + ev_to + ev_del - s0, 0);
        probe("t6_post", 32'h0000_0610, 8'h06);

        // ---- randomized phase ----
        for (int i = 0; i < NR; i++) begin
            tbl_mask[i]  = 32'hFFFF_FFF0 << (4 * $urandom_range(0, 3));
            tbl_key[i]   = 32'($urandom_range(0, 32'hFFF)) & tbl_mask[i];
            tbl_route[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        flush();
        tick(1);
        m0 = ev_miss; d0 = ev_del; t0 = ev_to;
        s0 = exp_miss; oc0 = exp_del;
        for (int i = 0; i < 800; i++) begin
            k = ($urandom_range(0, 9) == 0) ? 32'hDEAD_BEEF : 32'($urandom_range(0, 32'hFFF));
            in_data = mk_pkt(k);
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = 8'($urandom);
            @(posedge clk); #1;
        end
        in_vld = 1'b0; out_rdy = 8'hFF;
        tick(10);
        chk("rnd_q_empty", q_total(), 0);
        chk("rnd_del", ev_del - d0, exp_del - oc0);
        chk("rnd_miss", ev_miss - m0, exp_miss - s0);
        chk("rnd_to", ev_to - t0, 0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
